// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 size codes,
// FSM state type, byte-enable width and the store byte-enable helper.
package lsu_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Lane mask for a store of the given size at an (already aligned) byte offset.
    function automatic logic [BE_W-1:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return BE_W'(1) << off;
            SZ_HALF: return off[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
            default: return {BE_W{1'b1}};
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the byte/halfword/word out of a storage
// word and right-justifies it with sign or zero extension.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_unsigned;

    assign byte_sel    = word[8*off +: 8];
    assign half_sel    = word[16*off[1] +: 16];
    assign is_unsigned = funct3[2];

    always_comb begin
        data = word;
        case (funct3[1:0])
            SZ_BYTE: data = {{(XLEN-8){byte_sel[7] & ~is_unsigned}}, byte_sel};
            SZ_HALF: data = {{(XLEN-16){half_sel[15] & ~is_unsigned}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory with a request/response load-store unit (IDLE -> ACCESS -> RESP).
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault
// instead of being silently aligned down.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] write_data,
    output logic            resp_valid,
    output logic [XLEN-1:0] read_data,
    output logic            fault,
    output logic            stall
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    state_t          state;
    logic [3:0]      cnt;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;
    logic [2:0]      cap_f3;
    logic            cap_rd;
    logic            cap_wr;

    logic            in_idle;
    logic            accept;
    logic [XLEN-1:0] cur_addr;
    logic [XLEN-1:0] cur_wdata;
    logic [2:0]      cur_f3;
    logic            cur_rd;
    logic            cur_wr;
    logic [1:0]      eff_off;
    logic [AW-1:0]   cur_idx;
    logic            bad_f3;
    logic            out_range;
    logic            align_fault;
    logic            fault_c;
    logic            going_resp;
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] lane_data;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] resp_data_c;

    assign in_idle = (state == IDLE);
    assign accept  = in_idle && req_valid && (mem_read || mem_write);
    assign stall   = !req_ready;

    // With zero wait cycles the commit happens on the accepting edge itself,
    // so the live request fields are used while idle and the captured ones after.
    assign cur_addr  = in_idle ? addr       : cap_addr;
    assign cur_wdata = in_idle ? write_data : cap_wdata;
    assign cur_f3    = in_idle ? funct3     : cap_f3;
    assign cur_rd    = in_idle ? mem_read   : cap_rd;
    assign cur_wr    = in_idle ? mem_write  : cap_wr;

    always_comb begin
        eff_off = cur_addr[1:0];
        case (cur_f3[1:0])
            SZ_HALF: eff_off[0] = 1'b0;
            SZ_WORD: eff_off    = 2'b00;
            default: eff_off    = cur_addr[1:0];
        endcase
    end

    always_comb begin
        bad_f3 = 1'b0;
        if (cur_wr)
            bad_f3 = !(cur_f3 == F3_LB || cur_f3 == F3_LH || cur_f3 == F3_LW);
        else if (cur_rd)
            bad_f3 = !(cur_f3 == F3_LB || cur_f3 == F3_LH || cur_f3 == F3_LW ||
                       cur_f3 == F3_LBU || cur_f3 == F3_LHU);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign align_fault = ((cur_f3[1:0] == SZ_HALF) && cur_addr[0]) ||
                         ((cur_f3[1:0] == SZ_WORD) && (cur_addr[1:0] != 2'b00));
`else
    assign align_fault = 1'b0;
`endif

    assign cur_idx   = cur_addr[AW+1:2];
    assign out_range = (cur_addr >> (AW + 2)) != '0;
    assign fault_c   = (cur_rd && cur_wr) || bad_f3 || out_range || align_fault;

    assign going_resp = (state == ACCESS && cnt == 4'd0) || (accept && WAIT_CYCLES == 0);
    assign we         = rst_n && going_resp && cur_wr && !fault_c;
    assign be         = byte_enable(cur_f3[1:0], eff_off);

    always_comb begin
        lane_data = cur_wdata;
        for (int i = 0; i < BE_W; i++) begin
            case (cur_f3[1:0])
                SZ_BYTE: lane_data[8*i +: 8] = cur_wdata[7:0];
                SZ_HALF: lane_data[8*i +: 8] = cur_wdata[8*(i%2) +: 8];
                default: lane_data[8*i +: 8] = cur_wdata[8*i +: 8];
            endcase
        end
    end

    assign rd_word = mem[cur_idx];

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .word   (rd_word),
        .off    (eff_off),
        .funct3 (cur_f3),
        .data   (load_val)
    );

    assign resp_data_c = (cur_rd && !fault_c) ? load_val : '0;

    // Storage has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i])
                    mem[cur_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            read_data  <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_f3     <= 3'b000;
            cap_rd     <= 1'b0;
            cap_wr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_addr  <= addr;
                        cap_wdata <= write_data;
                        cap_f3    <= funct3;
                        cap_rd    <= mem_read;
                        cap_wr    <= mem_write;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            fault      <= fault_c;
                            read_data  <= resp_data_c;
                        end else begin
                            state <= ACCESS;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        fault      <= fault_c;
                        read_data  <= resp_data_c;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    fault      <= 1'b0;
                    read_data  <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu (default parameters).
module tb_data_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        fault;
    logic        stall;

    int          checks = 0;
    int          errors = 0;

    int          lat;
    logic        got;
    logic        stall_ok;
    logic        rsp_fault;
    logic [31:0] rsp_data;
    logic        seen_resp;

    data_mem_lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .write_data (write_data),
        .resp_valid (resp_valid),
        .read_data  (read_data),
        .fault      (fault),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and wait (bounded) for its response pulse.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        write_data = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        lat       = 0;
        got       = 1'b0;
        stall_ok  = 1'b1;
        rsp_fault = 1'b0;
        rsp_data  = 32'h0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (resp_valid === 1'b1) begin
                got       = 1'b1;
                rsp_fault = fault;
                rsp_data  = read_data;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_transaction(input string tag, input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] wd, input logic exp_fault,
                                     input logic [31:0] exp_data);
        apply_stimulus(rd, wr, f3, a, wd);
        check_output({tag, " resp_seen"}, 32'(got), 32'd1);
        check_output({tag, " latency"}, 32'(lat), 32'd2);
        check_output({tag, " stall"}, 32'(stall_ok), 32'd1);
        check_output({tag, " fault"}, 32'(rsp_fault), 32'(exp_fault));
        check_output({tag, " data"}, rsp_data, exp_data);
        check_output({tag, " idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        write_data = 32'h0;

        #12;
        check_output("rst req_ready", 32'(req_ready), 32'd1);
        check_output("rst resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst fault", 32'(fault), 32'd0);
        check_output("rst read_data", read_data, 32'h0);
        check_output("rst stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        check_transaction("sw 08", 1'b0, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0);
        check_transaction("lw 08", 1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF);
        check_transaction("lw 0c blank", 1'b1, 1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, 32'h0);

        check_transaction("sb 09", 1'b0, 1'b1, 3'b000, 32'h09, 32'h12345680, 1'b0, 32'h0);
        check_transaction("lb 09", 1'b1, 1'b0, 3'b000, 32'h09, 32'h0, 1'b0, 32'hFFFFFF80);
        check_transaction("lbu 09", 1'b1, 1'b0, 3'b100, 32'h09, 32'h0, 1'b0, 32'h00000080);
        check_transaction("lw 08 after sb", 1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEAD80EF);
        check_transaction("lh 0a", 1'b1, 1'b0, 3'b001, 32'h0A, 32'h0, 1'b0, 32'hFFFFDEAD);
        check_transaction("lhu 08", 1'b1, 1'b0, 3'b101, 32'h08, 32'h0, 1'b0, 32'h000080EF);

`ifdef LSU_MISALIGN_TRAP_EN
        check_transaction("lw 0a misaligned", 1'b1, 1'b0, 3'b010, 32'h0A, 32'h0, 1'b1, 32'h0);
        check_transaction("sw 0a misaligned", 1'b0, 1'b1, 3'b010, 32'h0A, 32'h0, 1'b1, 32'h0);
`else
        check_transaction("lw 0a aligned down", 1'b1, 1'b0, 3'b010, 32'h0A, 32'h0, 1'b0, 32'hDEAD80EF);
        check_transaction("lhu 0b aligned down", 1'b1, 1'b0, 3'b101, 32'h0B, 32'h0, 1'b0, 32'h0000DEAD);
`endif
        check_transaction("lw 08 unchanged", 1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEAD80EF);

        check_transaction("sw 10", 1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 32'h0);

        // Store accepted, then reset pulsed while it sits in ACCESS.
        req_valid  = 1'b1;
        mem_write  = 1'b1;
        funct3     = 3'b010;
        addr       = 32'h10;
        write_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_write = 1'b0;
        check_output("pre-reset stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst req_ready", 32'(req_ready), 32'd1);
        check_output("midrst stall", 32'(stall), 32'd0);
        check_output("midrst resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        seen_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen_resp = 1'b1;
        end
        check_output("no resp after reset", 32'(seen_resp), 32'd0);
        @(posedge clk); #1;
        check_transaction("lw 10 after reset", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h11223344);

        check_transaction("rd+wr 08", 1'b1, 1'b1, 3'b010, 32'h08, 32'h0, 1'b1, 32'h0);
        check_transaction("lw 08 after rdwr", 1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEAD80EF);
        check_transaction("load f3 011", 1'b1, 1'b0, 3'b011, 32'h08, 32'h0, 1'b1, 32'h0);
        check_transaction("store f3 100", 1'b0, 1'b1, 3'b100, 32'h08, 32'h0, 1'b1, 32'h0);
        check_transaction("lw 08 after bad st", 1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEAD80EF);
        check_transaction("lw 400 range", 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0);
        check_transaction("sw 408 range", 1'b0, 1'b1, 3'b010, 32'h408, 32'h55555555, 1'b1, 32'h0);
        check_transaction("lw 08 after range st", 1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEAD80EF);
        check_transaction("lw 3fc top", 1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0, 32'h0);

        check_transaction("sh 12", 1'b0, 1'b1, 3'b001, 32'h12, 32'h0000BEEF, 1'b0, 32'h0);
        check_transaction("lw 10 after sh", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hBEEF3344);

        // A valid request with no operation must be ignored.
        req_valid = 1'b1;
        addr      = 32'h08;
        seen_resp = 1'b0;
        stall_ok  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen_resp = 1'b1;
            if (req_ready !== 1'b1) stall_ok = 1'b0;
        end
        req_valid = 1'b0;
        check_output("noop no resp", 32'(seen_resp), 32'd0);
        check_output("noop stays ready", 32'(stall_ok), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
